cipher_encode: RTL
==================

// Module: cipher_encode
// PURPOSE
//  Encryption-side counterpart of the toy-RSA decode path: computes
//  cipherText = plainText^publicKey mod modulus by LSB-first square-and-multiply.
//  Each modular reduction uses a bit-serial restoring remainder unit.
//  Sits between the plaintext source and the decode path; cipherText feeds the decoder's cipherText input.
//  Uses a start/busy/done handshake.
// PARAMETERS
//  DATA_W  4  plaintext width (bits)
//  KEY_W   4  public exponent width (bits)
//  MOD_W   8  modulus / ciphertext width (bits); DATA_W <= MOD_W
// PORTS
//  CLK         in   1        single clock, all state changes on posedge
//  RST         in   1        asynchronous, active-high reset
//  start       in   1        request; sampled only while busy=0
//  plainText   in   DATA_W   message, latched on accepted start
//  publicKey   in   KEY_W    exponent e, latched on accepted start
//  modulus     in   MOD_W    N, latched on accepted start
//  cipherText  out  MOD_W    result; holds last value until next done
//  busy        out  1        high from accept edge until done edge
//  done        out  1        one-cycle pulse, result valid
//  err         out  1        valid with done; 1 = modulus was 0
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; cipherText=0, busy=0, done=0, err=0; all internal registers cleared.
//  - Reset mid-computation aborts the operation with no done pulse.
//  - FSM: IDLE -> LOAD -> RED0 -> {MUL, RED}* -> DONE -> IDLE.
//    ERR path: IDLE -> LOAD -> DONE with err=1.
//  - IDLE: start=1 latches inputs and sets busy=1. start while busy=1 is ignored (not queued).
//  - LOAD (1 cycle):
//    - N==0: go to DONE with err=1 and cipherText=0.
//    - Otherwise: base=zext(plainText); acc=(N==1)?0:1; bit index k=0.
//  - RED0: reduce base mod N, 2*MOD_W cycles.
//  - Per key bit k=0..KEY_W-1:
//    - If e[k]=1: MUL cycle acc*base (2*MOD_W-bit product), then RED of 2*MOD_W cycles; acc=remainder.
//    - If k<KEY_W-1: MUL cycle base*base, then RED; base=remainder.
//    - The square is skipped after the last bit.
//  - RED: restoring remainder, one product bit per cycle, MSB first. r=(r<<1|bit); if r>=N then r-=N.
//    r is MOD_W+1 bits wide, so there is no overflow.
//  - DONE (1 cycle): cipherText=acc (or 0 on err); done=1; busy=0 on the same edge; err held until next done.
//  - Latency, start edge to done edge, with R=2*MOD_W+1:
//    L = 1 + 2*MOD_W + (popcount(e)+KEY_W-1)*R + 1.
//    Err latency = 2 edges.
//  - Boundaries:
//    - e=0 gives 1 mod N.
//    - plainText>=N is reduced in RED0.
//    - N=1 gives 0.
//    - start held high re-triggers in the cycle after done.
//  - Intermediates never exceed 2*MOD_W bits. No combinational path from inputs to outputs.
// TESTING (DATA_W=4, KEY_W=4, MOD_W=8)
//  1. plain=2, e=3, N=33 -> cipherText=8, err=0, done exactly 103 edges after the start edge.
//  2. plain=4, e=7, N=33 -> cipherText=16, done at 120 edges.
//     Feed into the decode path with d=3 and check plaintext 4 is recovered.
//  3. plain=15, e=0, N=33 -> cipherText=1 at 69 edges; plain=9, e=5, N=1 -> cipherText=0.
//  4. N=0 -> done at 2 edges, err=1, cipherText=0; next valid request clears err.
//  5. start re-pulsed while busy, different inputs -> ignored; first result unchanged.
//     start held high -> back-to-back operations.
//  6. RST asserted mid-RED (edge 50 of case 2) -> outputs 0 asynchronously, no done.
//     New request after release is correct.

Source files
------------

// File: rtl/cipher_encode_if.sv
// Request/response bundle for the toy-RSA encryptor: the source drives start and operands,
// the encoder returns the ciphertext with a busy/done/err handshake.
interface cipher_encode_if #(
    parameter int DATA_W = 4,
    parameter int KEY_W  = 4,
    parameter int MOD_W  = 8
);
    logic              start;
    logic [DATA_W-1:0] plainText;
    logic [KEY_W-1:0]  publicKey;
    logic [MOD_W-1:0]  modulus;
    logic [MOD_W-1:0]  cipherText;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, plainText, publicKey, modulus,
        input  cipherText, busy, done, err
    );

    modport slave (
        input  start, plainText, publicKey, modulus,
        output cipherText, busy, done, err
    );
endinterface

// File: rtl/cipher_encode.sv
// Toy-RSA encryptor: cipherText = plainText^publicKey mod modulus, LSB-first
// square-and-multiply with a bit-serial restoring remainder after every product.
module cipher_encode #(
    parameter int DATA_W = 4,
    parameter int KEY_W  = 4,
    parameter int MOD_W  = 8
) (
    input  logic            CLK,
    input  logic            RST,
    cipher_encode_if.slave  bus
);
    localparam int PW = 2 * MOD_W;
    localparam int CW = (PW > 1) ? $clog2(PW) : 1;
    localparam int KW = (KEY_W > 1) ? $clog2(KEY_W) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(PW - 1);
    localparam logic [KW-1:0] LAST_K   = KW'(KEY_W - 1);

    typedef enum logic [2:0] {IDLE, LOAD, RED0, MUL, RED, DONE} state_t;
    state_t state, stateNext;

    logic [DATA_W-1:0] plainReg;
    logic [KEY_W-1:0]  keyReg;
    logic [MOD_W-1:0]  modReg;
    logic [MOD_W-1:0]  baseReg;
    logic [MOD_W-1:0]  accReg;
    logic [PW-1:0]     prodReg;
    logic [MOD_W:0]    remReg;
    logic [CW-1:0]     cntReg;
    logic [KW-1:0]     kReg;
    logic              mulDoneReg;
    logic              toBaseReg;
    logic              errFlagReg;
    logic [MOD_W-1:0]  cipherReg;
    logic              busyReg;
    logic              doneReg;
    logic              errReg;

    logic [MOD_W:0]    remShift;
    logic [MOD_W:0]    remNext;
    logic              redLast;
    logic              wantMul;
    logic              wantSq;

    // r < N before the shift, so (r<<1)|bit always fits in MOD_W+1 bits.
    assign remShift = {remReg[MOD_W-1:0], prodReg[PW-1]};
    assign remNext  = (remShift >= {1'b0, modReg}) ? (remShift - {1'b0, modReg}) : remShift;
    assign redLast  = (cntReg == LAST_CNT);

    // Position in the key: the multiply for bit k is pending until mulDoneReg is set;
    // a square advances k, and no square follows the last key bit.
    assign wantMul  = !mulDoneReg && keyReg[kReg];
    assign wantSq   = (kReg != LAST_K);

    assign bus.cipherText = cipherReg;
    assign bus.busy       = busyReg;
    assign bus.done       = doneReg;
    assign bus.err        = errReg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:      if (bus.start) stateNext = LOAD;
            LOAD:      stateNext = (modReg == '0) ? DONE : RED0;
            RED0, RED: if (redLast) stateNext = (wantMul || wantSq) ? MUL : DONE;
            MUL:       stateNext = RED;
            DONE:      stateNext = IDLE;
            default:   stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            plainReg   <= '0;
            keyReg     <= '0;
            modReg     <= '0;
            baseReg    <= '0;
            accReg     <= '0;
            prodReg    <= '0;
            remReg     <= '0;
            cntReg     <= '0;
            kReg       <= '0;
            mulDoneReg <= 1'b0;
            toBaseReg  <= 1'b0;
            errFlagReg <= 1'b0;
            cipherReg  <= '0;
            busyReg    <= 1'b0;
            doneReg    <= 1'b0;
            errReg     <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        plainReg <= bus.plainText;
                        keyReg   <= bus.publicKey;
                        modReg   <= bus.modulus;
                        busyReg  <= 1'b1;
                    end
                end
                LOAD: begin
                    errFlagReg <= (modReg == '0);
                    baseReg    <= MOD_W'(plainReg);
                    accReg     <= (modReg == MOD_W'(1)) ? '0 : MOD_W'(1);
                    prodReg    <= PW'(plainReg);
                    remReg     <= '0;
                    cntReg     <= '0;
                    kReg       <= '0;
                    mulDoneReg <= 1'b0;
                    toBaseReg  <= 1'b1;
                end
                MUL: begin
                    remReg <= '0;
                    cntReg <= '0;
                    if (wantMul) begin
                        prodReg    <= PW'(accReg) * PW'(baseReg);
                        toBaseReg  <= 1'b0;
                        mulDoneReg <= 1'b1;
                    end else begin
                        prodReg    <= PW'(baseReg) * PW'(baseReg);
                        toBaseReg  <= 1'b1;
                        mulDoneReg <= 1'b0;
                        kReg       <= kReg + 1'b1;
                    end
                end
                RED0, RED: begin
                    remReg  <= remNext;
                    prodReg <= {prodReg[PW-2:0], 1'b0};
                    cntReg  <= cntReg + 1'b1;
                    if (redLast) begin
                        if (toBaseReg) baseReg <= remNext[MOD_W-1:0];
                        else           accReg  <= remNext[MOD_W-1:0];
                    end
                end
                DONE: begin
                    cipherReg <= errFlagReg ? '0 : accReg;
                    errReg    <= errFlagReg;
                    doneReg   <= 1'b1;
                    busyReg   <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
